// File: rtl/crack_pkg.sv
// crack_pkg: shared state encoding and constants for the crack_range key search.
package crack_pkg;
    localparam int KEY_W = 24;
    localparam int MSG_LEN_W = 8;
    localparam logic [7:0] DEF_CHAR_LO = 8'h20;
    localparam logic [7:0] DEF_CHAR_HI = 8'h7E;
    typedef enum logic [3:0] {
        IDLE, RANGE_CHK, ARC4_GO, ARC4_BUSY, ARC4_DONE, LEN_RD,
        LEN_LATCH, SCAN_RD, SCAN_CHK, NEXT_KEY, FOUND, DONE
    } state_t;
endpackage

// File: rtl/arc4.sv
// arc4: ARC4 decryptor; ct[0] is the length byte copied to pt[0], ct[1..len] are decrypted into pt.
// Key byte order is key[23:16], key[15:8], key[7:0], repeating.
module arc4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    output logic [7:0]  pt_addr,
    output logic [7:0]  pt_wrdata,
    output logic        pt_wren
);
    typedef enum logic [2:0] {A_IDLE, A_INIT, A_KSA, A_LEN, A_LENW, A_PRGA, A_XOR} astate_t;
    astate_t state;
    logic [7:0] s [256];
    logic [7:0] cnt, i, j, len, pad, kb, jk, in, jn, si, sj, t, pn;
    logic [1:0] m3;
    logic [23:0] key_q;
    assign kb = m3 == 2'd0 ? key_q[23:16] : m3 == 2'd1 ? key_q[15:8] : key_q[7:0];
    assign jk = j + s[cnt] + kb;
    assign in = i + 8'd1;
    assign si = s[in];
    assign jn = j + si;
    assign sj = s[jn];
    assign t = si + sj;
    // keystream byte is read from the post-swap table
    assign pn = t == in ? sj : t == jn ? si : s[t];
    assign rdy = state == A_IDLE;
    assign ct_addr = state == A_PRGA ? cnt : 8'h00;
    assign pt_addr = state == A_XOR ? cnt : 8'h00;
    assign pt_wrdata = state == A_XOR ? pad ^ ct_rddata : ct_rddata;
    assign pt_wren = state == A_LENW || state == A_XOR;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= A_IDLE;
            cnt <= '0;
            i <= '0;
            j <= '0;
            len <= '0;
            pad <= '0;
            m3 <= '0;
            key_q <= '0;
        end else begin
            case (state)
                A_IDLE: if (en) begin
                    key_q <= key;
                    cnt <= '0;
                    state <= A_INIT;
                end
                A_INIT: begin
                    s[cnt] <= cnt;
                    cnt <= cnt + 8'd1;
                    j <= '0;
                    m3 <= '0;
                    if (cnt == 8'hFF) state <= A_KSA;
                end
                A_KSA: begin
                    s[cnt] <= s[jk];
                    s[jk] <= s[cnt];
                    j <= jk;
                    cnt <= cnt + 8'd1;
                    m3 <= m3 == 2'd2 ? 2'd0 : m3 + 2'd1;
                    if (cnt == 8'hFF) state <= A_LEN;
                end
                A_LEN: begin
                    i <= '0;
                    j <= '0;
                    cnt <= 8'd1;
                    state <= A_LENW;
                end
                A_LENW: begin
                    len <= ct_rddata;
                    state <= ct_rddata == 8'h00 ? A_IDLE : A_PRGA;
                end
                A_PRGA: begin
                    s[in] <= sj;
                    s[jn] <= si;
                    i <= in;
                    j <= jn;
                    pad <= pn;
                    state <= A_XOR;
                end
                A_XOR: begin
                    cnt <= cnt + 8'd1;
                    state <= cnt == len ? A_IDLE : A_PRGA;
                end
                default: state <= A_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/pt_mem.sv
// pt_mem: 256x8 plaintext memory with one-cycle registered read.
module pt_mem (
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic [7:0] wrdata,
    input  logic       wren,
    output logic [7:0] rddata
);
    logic [7:0] mem [256];
    always_ff @(posedge clk) begin
        if (wren) mem[addr] <= wrdata;
        rddata <= mem[addr];
    end
endmodule

// File: rtl/pt_scan.sv
// pt_scan: message length latch, scan index and printable-byte comparator over pt_mem.
module pt_scan
    import crack_pkg::*;
#(
    parameter logic [7:0] CHAR_LO = DEF_CHAR_LO,
    parameter logic [7:0] CHAR_HI = DEF_CHAR_HI
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [MSG_LEN_W-1:0] rddata,
    output logic [MSG_LEN_W-1:0] addr,
    output logic                 pass,
    output logic                 fail
);
    logic [MSG_LEN_W-1:0] len;
    logic [MSG_LEN_W:0] idx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len <= '0;
            idx <= '0;
        end else if (start) begin
            len <= rddata;
            idx <= (MSG_LEN_W+1)'(1);
        end else if (step) begin
            idx <= idx + 1'b1;
        end
    end
    // index is one bit wider so len=255 ends at 256 without wrapping
    assign addr = idx[MSG_LEN_W-1:0];
    assign pass = idx > {1'b0, len};
    assign fail = rddata < CHAR_LO || rddata > CHAR_HI;
endmodule

// File: rtl/crack_range.sv
// crack_range: ARC4 brute-force search over [key_start, key_end] stepping by KEY_STRIDE.
// Define CRACK_KEYCNT_EN to build the saturating keys_tried counter; otherwise it reads 0.
module crack_range
    import crack_pkg::*;
#(
    parameter int         KEY_STRIDE = 2,
    parameter logic [7:0] CHAR_LO    = DEF_CHAR_LO,
    parameter logic [7:0] CHAR_HI    = DEF_CHAR_HI
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_start,
    input  logic [KEY_W-1:0] key_end,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic [31:0]      keys_tried,
    output logic [7:0]       ct_addr,
    input  logic [7:0]       ct_rddata
);
    localparam logic [KEY_W:0] STEP = (KEY_W+1)'(KEY_STRIDE);
    state_t state;
    logic [KEY_W:0] key_r;
    logic [KEY_W-1:0] end_r;
    logic abort_q, a_en, a_rdy, a_wren, p_wren, arc4_sel, scan_pass, scan_fail;
    logic [7:0] a_addr, a_wrdata, p_addr, p_rddata, s_addr;
    assign key = key_r[KEY_W-1:0];
    assign a_en = state == ARC4_GO;
    assign arc4_sel = state == ARC4_GO || state == ARC4_BUSY || state == ARC4_DONE;
    assign p_addr = arc4_sel ? a_addr : state == LEN_RD ? 8'h00 : s_addr;
    assign p_wren = arc4_sel && a_wren;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy <= 1'b1;
            key_valid <= 1'b0;
            key_r <= '0;
            end_r <= '0;
            abort_q <= 1'b0;
        end else begin
            if (state != IDLE && abort) abort_q <= 1'b1;
            case (state)
                IDLE: if (en) begin
                    state <= RANGE_CHK;
                    rdy <= 1'b0;
                    key_valid <= 1'b0;
                    key_r <= {1'b0, key_start};
                    end_r <= key_end;
                    abort_q <= 1'b0;
                end
                // bit KEY_W is the carry out of the stride add: the search wrapped
                RANGE_CHK: state <= abort_q || key_r[KEY_W] || key_r[KEY_W-1:0] > end_r ? DONE : ARC4_GO;
                ARC4_GO:   state <= ARC4_BUSY;
                ARC4_BUSY: if (!a_rdy) state <= ARC4_DONE;
                ARC4_DONE: if (a_rdy) state <= LEN_RD;
                LEN_RD:    state <= LEN_LATCH;
                LEN_LATCH: state <= SCAN_RD;
                SCAN_RD:   state <= scan_pass ? FOUND : SCAN_CHK;
                SCAN_CHK:  state <= scan_fail ? NEXT_KEY : SCAN_RD;
                NEXT_KEY: begin
                    key_r <= key_r + STEP;
                    state <= RANGE_CHK;
                end
                FOUND: begin
                    key_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    rdy <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef CRACK_KEYCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && en)) keys_tried <= '0;
        else if ((state == NEXT_KEY || state == FOUND) && keys_tried != '1) keys_tried <= keys_tried + 1'b1;
    end
`else
    assign keys_tried = '0;
`endif
    arc4 u_arc4 (
        .clk(clk),
        .rst_n(rst_n),
        .en(a_en),
        .rdy(a_rdy),
        .key(key_r[KEY_W-1:0]),
        .ct_addr(ct_addr),
        .ct_rddata(ct_rddata),
        .pt_addr(a_addr),
        .pt_wrdata(a_wrdata),
        .pt_wren(a_wren)
    );
    pt_mem u_pt_mem (
        .clk(clk),
        .addr(p_addr),
        .wrdata(a_wrdata),
        .wren(p_wren),
        .rddata(p_rddata)
    );
    pt_scan #(.CHAR_LO(CHAR_LO), .CHAR_HI(CHAR_HI)) u_scan (
        .clk(clk),
        .rst_n(rst_n),
        .start(state == LEN_LATCH),
        .step(state == SCAN_CHK && !scan_fail),
        .rddata(p_rddata),
        .addr(s_addr),
        .pass(scan_pass),
        .fail(scan_fail)
    );
endmodule

// File: tb/tb_crack_range.sv
// tb_crack_range: directed scoreboard bench for crack_range against a behavioural ARC4 model.
module tb_crack_range;
    import crack_pkg::*;
    localparam int STRIDE = 2;
    typedef struct packed {
        logic        v;
        logic [23:0] k;
        logic [31:0] n;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, abort = 1'b0;
    logic rdy, key_valid;
    logic [23:0] key_start = '0, key_end = '0, key;
    logic [31:0] keys_tried;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] ct_mem [256];
    logic [7:0] ms [256];
    logic [7:0] mi, mj;
    exp_t sb [$];
    int vectors = 0, misses = 0, pulses_cnt = 0;
    int cyc, pul;
    string msg = "Hello, ARC4 world!";
    always #5 clk = ~clk;
    always @(posedge clk) ct_rddata <= ct_mem[ct_addr];
    always @(posedge clk) if (dut.a_en) pulses_cnt <= pulses_cnt + 1;
    crack_range #(.KEY_STRIDE(STRIDE)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .abort(abort),
        .key_start(key_start), .key_end(key_end), .key(key), .key_valid(key_valid),
        .keys_tried(keys_tried), .ct_addr(ct_addr), .ct_rddata(ct_rddata)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic rc4_init(input logic [23:0] k);
        logic [7:0] t;
        for (int x = 0; x < 256; x++) ms[x] = x[7:0];
        mj = 0;
        for (int x = 0; x < 256; x++) begin
            mj = mj + ms[x] + k[23 - 8 * (x % 3) -: 8];
            t = ms[x]; ms[x] = ms[mj]; ms[mj] = t;
        end
        mi = 0;
        mj = 0;
    endtask
    task automatic rc4_pad(output logic [7:0] p);
        logic [7:0] t;
        mi = mi + 8'd1;
        mj = mj + ms[mi];
        t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
        t = ms[mi] + ms[mj];
        p = ms[t];
    endtask
    task automatic make_ct(input logic [23:0] k, input string m);
        logic [7:0] p;
        ct_mem[0] = 8'(m.len());
        rc4_init(k);
        for (int n = 1; n <= m.len(); n++) begin
            rc4_pad(p);
            ct_mem[n] = m[n-1] ^ p;
        end
    endtask
    task automatic key_ok(input logic [23:0] k, output bit ok);
        logic [7:0] p, b;
        rc4_init(k);
        ok = 1;
        for (int n = 1; n <= int'(ct_mem[0]); n++) begin
            rc4_pad(p);
            b = ct_mem[n] ^ p;
            if (b < 8'h20 || b > 8'h7E) begin
                ok = 0;
                break;
            end
        end
    endtask
    task automatic model(input logic [24:0] s, input logic [23:0] e, output exp_t x);
        logic [24:0] k = s;
        bit ok;
        int g = 0;
        x = '0;
        while (k <= {1'b0, e} && g < 64) begin
            x.n++;
            g++;
            key_ok(k[23:0], ok);
            if (ok) begin
                x.v = 1;
                break;
            end
            k = k + 25'(STRIDE);
        end
        x.k = k[23:0];
`ifndef CRACK_KEYCNT_EN
        x.n = 0;
`endif
    endtask
    task automatic run(input logic [23:0] s, input logic [23:0] e, input logic [23:0] me,
                       input int ab, input int budget, output int cycles, output int pulses);
        exp_t x;
        int p0;
        model({1'b0, s}, me, x);
        sb.push_back(x);
        p0 = pulses_cnt;
        key_start = s;
        key_end = e;
        en = 1;
        @(negedge clk);
        en = 0;
        chk("rdy_low_after_accept", rdy, 0);
        cycles = 0;
        while (!rdy && cycles < budget) begin
            abort = cycles == ab;
            en = cycles == 5;
            key_start = cycles == 5 ? s ^ 24'h800000 : s;
            @(negedge clk);
            cycles++;
        end
        abort = 0;
        en = 0;
        key_start = s;
        chk("done_in_budget", rdy, 1);
        if (!rdy) begin
            rst_n = 0;
            @(negedge clk);
            rst_n = 1;
        end
        x = sb.pop_front();
        chk("key_valid", key_valid, x.v);
        chk("key", key, x.k);
        chk("keys_tried", keys_tried, x.n);
        pulses = pulses_cnt - p0;
    endtask
    initial begin
        make_ct(24'h00001A, msg);
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy, 1);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key", key, 0);
        chk("rst_keys_tried", keys_tried, 0);
        rst_n = 1;
        @(negedge clk);
        run(24'h000000, 24'hFFFFFF, 24'hFFFFFF, -1, 20000, cyc, pul);
        chk("found_key_const", key, 24'h00001A);
        abort = 1;
        @(negedge clk);
        abort = 0;
        run(24'h000001, 24'h000021, 24'h000021, -1, 20000, cyc, pul);
        chk("odd_lane_end_key", key, 24'h000023);
        run(24'h000005, 24'h000003, 24'h000003, -1, 50, cyc, pul);
        chk("empty_range_cycles", cyc, 2);
        chk("empty_range_arc4_runs", pul, 0);
        run(24'h000100, 24'hFFFFFF, 24'h000100, 2, 800, cyc, pul);
        chk("abort_arc4_runs", pul, 1);
        run(24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFF, -1, 2000, cyc, pul);
        chk("wrap_arc4_runs", pul, 1);
        ct_mem[0] = 8'h00;
        run(24'h000077, 24'hFFFFFF, 24'hFFFFFF, -1, 2000, cyc, pul);
        make_ct(24'h00001A, msg);
        key_start = 24'h000040;
        key_end = 24'hFFFFFF;
        en = 1;
        @(negedge clk);
        en = 0;
        cyc = 0;
        while (dut.state != SCAN_CHK && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_scan", dut.state == SCAN_CHK, 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("midrst_rdy", rdy, 1);
        chk("midrst_key_valid", key_valid, 0);
        chk("midrst_key", key, 0);
        chk("midrst_keys_tried", keys_tried, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
